// File: rtl/readout_rx_demod_unit.sv
// readout_rx_demod_unit
// Receive-side digital down-converter for resonator readout. Each accepted
// ADC sample is multiplied by a cosine and a sine looked up from a writable
// LUT at the current NCO phase. The products are integrated over a
// programmable number of samples, and one signed I/Q pair is dumped per window.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   nco_ftw_wr_en/nco_ftw_in  frequency tuning word load
//   sin_lut_wr_*              sine LUT write port (contents survive reset)
//   integ_len_wr_en/_in       samples per integration window
//   start_in                  start a window (honoured in IDLE only)
//   adc_valid_in/adc_data_in  signed ADC samples (honoured in INTEG only)
//   busy_out                  high while a window is in progress
//   valid_iq_out              one-cycle pulse when i_out/q_out update
//   i_out, q_out              integrated I = sum adc*cos, Q = sum adc*sin
//
// state | meaning
// IDLE  | waiting for start_in
// INTEG | accepting samples until the window length is reached
// DRAIN | letting the multiply/accumulate pipeline empty
// DONE  | result presented, valid_iq_out high for one cycle
module readout_rx_demod_unit #(
    parameter int NCO_N              = 22,
    parameter int PHASE_WIDTH        = 10,
    parameter int SIN_LUT_NUM_ENTRY  = 1024,
    parameter int SIN_LUT_DATA_WIDTH = 16,
    parameter int ADC_WIDTH          = 8,
    parameter int ACC_WIDTH          = 40,
    parameter int INTEG_CNT_WIDTH    = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 nco_ftw_wr_en,
    input  logic [NCO_N-1:0]                     nco_ftw_in,
    input  logic                                 sin_lut_wr_en,
    input  logic [PHASE_WIDTH-1:0]               sin_lut_wr_addr,
    input  logic signed [SIN_LUT_DATA_WIDTH-1:0] sin_lut_wr_data,
    input  logic                                 integ_len_wr_en,
    input  logic [INTEG_CNT_WIDTH-1:0]           integ_len_in,
    input  logic                                 start_in,
    input  logic                                 adc_valid_in,
    input  logic signed [ADC_WIDTH-1:0]          adc_data_in,
    output logic                                 busy_out,
    output logic                                 valid_iq_out,
    output logic signed [ACC_WIDTH-1:0]          i_out,
    output logic signed [ACC_WIDTH-1:0]          q_out
);

    localparam int PROD_W = ADC_WIDTH + SIN_LUT_DATA_WIDTH;
    localparam logic [PHASE_WIDTH-1:0] QUARTER_TURN = PHASE_WIDTH'(SIN_LUT_NUM_ENTRY / 4);

    typedef enum logic [1:0] {IDLE, INTEG, DRAIN, DONE} state_t;

    state_t state, state_next;

    logic [NCO_N-1:0]           ftw;
    logic [INTEG_CNT_WIDTH-1:0] integ_len;
    logic [INTEG_CNT_WIDTH-1:0] len_lat;
    logic [INTEG_CNT_WIDTH-1:0] cnt;
    logic [INTEG_CNT_WIDTH-1:0] cnt_inc;
    logic [NCO_N-1:0]           phase_acc;
    logic [PHASE_WIDTH-1:0]     phase;
    logic [1:0]                 drain_cnt;

    logic signed [SIN_LUT_DATA_WIDTH-1:0] lut [SIN_LUT_NUM_ENTRY];

    logic                                 s0_valid, s1_valid, s2_valid;
    logic signed [ADC_WIDTH-1:0]          s0_adc, s1_adc;
    logic [PHASE_WIDTH-1:0]               s0_sin_addr, s0_cos_addr;
    logic signed [SIN_LUT_DATA_WIDTH-1:0] s1_sin, s1_cos;
    logic signed [PROD_W-1:0]             s2_prod_i, s2_prod_q;

    logic signed [ACC_WIDTH-1:0] acc_i, acc_q, acc_i_next, acc_q_next;

    logic start_go, accept, last_sample, drain_done;

    assign start_go    = (state == IDLE) && start_in;
    assign accept      = (state == INTEG) && adc_valid_in;
    assign cnt_inc     = cnt + INTEG_CNT_WIDTH'(1);
    assign last_sample = accept && (cnt_inc == len_lat);
    assign phase       = phase_acc[NCO_N-1 -: PHASE_WIDTH];

    // The final product sits in s2 during the last DRAIN cycle and is folded
    // into the result on the same edge that enters DONE, so the drain is a
    // fixed three cycles and needs only the two earlier stages to be empty.
    assign drain_done = (drain_cnt == 2'd0) && !s0_valid && !s1_valid;

    assign acc_i_next = acc_i + (s2_valid ? ACC_WIDTH'(s2_prod_i) : '0);
    assign acc_q_next = acc_q + (s2_valid ? ACC_WIDTH'(s2_prod_q) : '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        busy_out     = (state != IDLE);
        valid_iq_out = 1'b0;
        case (state)
            IDLE:  if (start_in) state_next = (integ_len == '0) ? DRAIN : INTEG;
            INTEG: if (last_sample) state_next = DRAIN;
            DRAIN: if (drain_done) state_next = DONE;
            DONE: begin
                valid_iq_out = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ftw       <= '0;
            integ_len <= '0;
            len_lat   <= '0;
            cnt       <= '0;
            phase_acc <= '0;
            drain_cnt <= '0;
            s0_valid  <= 1'b0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            acc_i     <= '0;
            acc_q     <= '0;
            i_out     <= '0;
            q_out     <= '0;
        end else begin
            if (nco_ftw_wr_en)   ftw       <= nco_ftw_in;
            if (integ_len_wr_en) integ_len <= integ_len_in;

            if (start_go) begin
                len_lat   <= integ_len;
                cnt       <= '0;
                phase_acc <= '0;
            end else if (accept) begin
                cnt       <= cnt_inc;
                phase_acc <= phase_acc + ftw;
            end

            if (state_next == DRAIN && state != DRAIN) drain_cnt <= 2'd2;
            else if (state == DRAIN && drain_cnt != 2'd0) drain_cnt <= drain_cnt - 2'd1;

            s0_valid <= accept;
            s1_valid <= s0_valid;
            s2_valid <= s1_valid;

            if (start_go) begin
                acc_i <= '0;
                acc_q <= '0;
            end else begin
                acc_i <= acc_i_next;
                acc_q <= acc_q_next;
            end

            if (state_next == DONE) begin
                i_out <= acc_i_next;
                q_out <= acc_q_next;
            end
        end
    end

    // Datapath and LUT storage carry no reset; only the valids qualify them.
    // Nonblocking reads give old data on a same-address write.
    always_ff @(posedge clk) begin
        if (sin_lut_wr_en) lut[sin_lut_wr_addr] <= sin_lut_wr_data;
        if (accept) begin
            s0_adc      <= adc_data_in;
            s0_sin_addr <= phase;
            s0_cos_addr <= phase + QUARTER_TURN;
        end
        s1_adc    <= s0_adc;
        s1_sin    <= lut[s0_sin_addr];
        s1_cos    <= lut[s0_cos_addr];
        s2_prod_i <= PROD_W'(s1_adc) * PROD_W'(s1_cos);
        s2_prod_q <= PROD_W'(s1_adc) * PROD_W'(s1_sin);
    end

endmodule

// File: tb/tb_readout_rx_demod_unit.sv
module tb_readout_rx_demod_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        nco_ftw_wr_en;
    logic [21:0] nco_ftw_in;
    logic        sin_lut_wr_en;
    logic [9:0]  sin_lut_wr_addr;
    logic signed [15:0] sin_lut_wr_data;
    logic        integ_len_wr_en;
    logic [15:0] integ_len_in;
    logic        start_in;
    logic        adc_valid_in;
    logic signed [7:0] adc_data_in;

    logic busy_out, valid_iq_out, busy24, valid24;
    logic signed [39:0] i_out, q_out;
    logic signed [23:0] i24, q24;

    always #5 clk = ~clk;

    readout_rx_demod_unit u_dut (
        .clk(clk), .rst(rst),
        .nco_ftw_wr_en(nco_ftw_wr_en), .nco_ftw_in(nco_ftw_in),
        .sin_lut_wr_en(sin_lut_wr_en), .sin_lut_wr_addr(sin_lut_wr_addr),
        .sin_lut_wr_data(sin_lut_wr_data),
        .integ_len_wr_en(integ_len_wr_en), .integ_len_in(integ_len_in),
        .start_in(start_in), .adc_valid_in(adc_valid_in), .adc_data_in(adc_data_in),
        .busy_out(busy_out), .valid_iq_out(valid_iq_out), .i_out(i_out), .q_out(q_out)
    );

    readout_rx_demod_unit #(.ACC_WIDTH(24)) u_dut24 (
        .clk(clk), .rst(rst),
        .nco_ftw_wr_en(nco_ftw_wr_en), .nco_ftw_in(nco_ftw_in),
        .sin_lut_wr_en(sin_lut_wr_en), .sin_lut_wr_addr(sin_lut_wr_addr),
        .sin_lut_wr_data(sin_lut_wr_data),
        .integ_len_wr_en(integ_len_wr_en), .integ_len_in(integ_len_in),
        .start_in(start_in), .adc_valid_in(adc_valid_in), .adc_data_in(adc_data_in),
        .busy_out(busy24), .valid_iq_out(valid24), .i_out(i24), .q_out(q24)
    );

    int checks = 0;
    int failures = 0;

    // Reference state: LUT image, tuning word, and the samples of the window.
    int     lut_m [1024];
    longint ftw_m;
    int     samp_q[$];
    int     fix_q[$];
    bit     pat_q[$];

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint wrap(input longint v, input int w);
        longint m = longint'(1) << w;
        longint r = v & (m - 1);
        if (r >= (m >> 1)) r -= m;
        return r;
    endfunction

    // Sample k sits at phase k*FTW; its LUT index is the top 10 of 22 bits,
    // cosine a quarter turn ahead.
    function automatic longint ref_iq(input bit is_q, input int w);
        longint s = 0;
        for (int k = 0; k < samp_q.size(); k++) begin
            int p = int'(((longint'(k) * ftw_m) % (longint'(1) << 22)) >> 12);
            int a = is_q ? p : (p + 256) % 1024;
            s += longint'(samp_q[k]) * longint'(lut_m[a]);
        end
        return wrap(s, w);
    endfunction

    task automatic write_ftw(input longint v);
        @(negedge clk);
        nco_ftw_wr_en = 1'b1;
        nco_ftw_in    = 22'(v);
        ftw_m         = v % (longint'(1) << 22);
        @(negedge clk);
        nco_ftw_wr_en = 1'b0;
    endtask

    task automatic write_len(input int v);
        @(negedge clk);
        integ_len_wr_en = 1'b1;
        integ_len_in    = 16'(v);
        @(negedge clk);
        integ_len_wr_en = 1'b0;
    endtask

    task automatic write_lut(input int addr, input int data);
        @(negedge clk);
        sin_lut_wr_en   = 1'b1;
        sin_lut_wr_addr = 10'(addr);
        sin_lut_wr_data = 16'(data);
        lut_m[addr]     = data;
        @(negedge clk);
        sin_lut_wr_en = 1'b0;
    endtask

    // Runs one window from start to result. Sample values come from fix_q
    // when given, otherwise random; valid pattern from pat_q, then gap_pct.
    task automatic run_window(input int len, input int gap_pct, input bit poke_start,
                              input string tag);
        int  k = 0;
        int  slot = 0;
        bit  v;
        byte d;
        samp_q.delete();
        @(negedge clk);
        start_in     = 1'b1;
        adc_valid_in = 1'b1;
        adc_data_in  = 8'sd77;
        @(negedge clk);
        start_in = 1'b0;
        check({tag, "_busy"}, longint'(busy_out), 1);
        while (k < len) begin
            if (slot > 4000) begin
                failures++;
                $error("FAIL %s_slot_budget observed=%0d expected=%0d", tag, k, len);
                break;
            end
            v = (slot < pat_q.size()) ? pat_q[slot] : ($urandom_range(0, 99) >= gap_pct);
            d = (v && k < fix_q.size()) ? byte'(fix_q[k]) : byte'($urandom_range(0, 255));
            adc_valid_in = v;
            adc_data_in  = d;
            start_in     = poke_start && (slot == 1);
            if (v) begin
                samp_q.push_back(int'(d));
                k++;
            end
            slot++;
            @(negedge clk);
        end
        start_in     = 1'b0;
        adc_valid_in = 1'b1;
        adc_data_in  = 8'sh55;
        for (int n = 1; n <= 3; n++) begin
            check({tag, "_early_valid"}, longint'(valid_iq_out), 0);
            @(negedge clk);
        end
        check({tag, "_valid"}, longint'(valid_iq_out), 1);
        check({tag, "_i"}, longint'(i_out), ref_iq(1'b0, 40));
        check({tag, "_q"}, longint'(q_out), ref_iq(1'b1, 40));
        check({tag, "_valid24"}, longint'(valid24), 1);
        check({tag, "_i24"}, longint'(i24), ref_iq(1'b0, 24));
        check({tag, "_q24"}, longint'(q24), ref_iq(1'b1, 24));
        @(negedge clk);
        adc_valid_in = 1'b0;
        check({tag, "_valid_after"}, longint'(valid_iq_out), 0);
        check({tag, "_busy_after"}, longint'(busy_out), 0);
        fix_q.delete();
        pat_q.delete();
    endtask

    initial begin
        int pulses;
        rst = 1'b1;
        nco_ftw_wr_en = 1'b0; nco_ftw_in = '0;
        sin_lut_wr_en = 1'b0; sin_lut_wr_addr = '0; sin_lut_wr_data = '0;
        integ_len_wr_en = 1'b0; integ_len_in = '0;
        start_in = 1'b0; adc_valid_in = 1'b0; adc_data_in = '0;
        ftw_m = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", longint'(busy_out), 0);
        check("rst_valid", longint'(valid_iq_out), 0);
        check("rst_i", longint'(i_out), 0);
        check("rst_q", longint'(q_out), 0);
        rst = 1'b0;

        for (int a = 0; a < 1024; a++) begin
            @(negedge clk);
            sin_lut_wr_en   = 1'b1;
            sin_lut_wr_addr = 10'(a);
            lut_m[a]        = int'(32767.0 * $sin(2.0 * 3.141592653589793 * a / 1024.0));
            sin_lut_wr_data = 16'(lut_m[a]);
        end
        @(negedge clk);
        sin_lut_wr_en = 1'b0;

        // DC input, zero frequency
        write_ftw(0);
        write_len(4);
        fix_q = '{10, 10, 10, 10};
        run_window(4, 0, 1'b0, "dc");

        // Quarter turn per sample
        write_ftw(longint'(1) << 20);
        fix_q = '{1, 0, -1, 0};
        run_window(4, 0, 1'b0, "qt_i");
        fix_q = '{0, 1, 0, -1};
        run_window(4, 0, 1'b0, "qt_q");

        // Same with gaps
        fix_q = '{1, 0, -1, 0};
        pat_q = '{1, 0, 0, 1, 1, 0, 1};
        run_window(4, 0, 1'b0, "gaps");

        // Zero length
        write_len(0);
        run_window(0, 0, 1'b0, "len0");

        // Start reasserted mid-window is ignored
        write_ftw(12345);
        write_len(6);
        run_window(6, 20, 1'b1, "restart");

        // Reset mid-window aborts without a pulse
        write_len(10);
        @(negedge clk);
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        adc_valid_in = 1'b1;
        adc_data_in  = 8'sd100;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        adc_valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ftw_m = 0;
        check("abort_busy", longint'(busy_out), 0);
        check("abort_i", longint'(i_out), 0);
        check("abort_q", longint'(q_out), 0);
        pulses = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (valid_iq_out) pulses++;
        end
        check("abort_no_pulse", longint'(pulses), 0);
        write_ftw(777777);
        write_len(5);
        run_window(5, 0, 1'b0, "after_rst");

        // Narrow accumulator: fits at length 2, wraps at length 3
        write_ftw(0);
        write_len(2);
        fix_q = '{127, 127};
        run_window(2, 0, 1'b0, "acc24_len2");
        write_len(3);
        fix_q = '{127, 127, 127};
        run_window(3, 0, 1'b0, "acc24_wrap");

        // Randomized windows with LUT rewrites
        for (int r = 0; r < 6; r++) begin
            int len;
            for (int w = 0; w < 3; w++)
                write_lut(int'($urandom_range(0, 1023)), int'($urandom_range(0, 65535)) - 32768);
            write_ftw(longint'($urandom_range(0, (1 << 22) - 1)));
            len = int'($urandom_range(1, 24));
            write_len(len);
            run_window(len, 30, 1'b0, $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
